cam_scaler: RTL and testbench

CAM_SCALER -- requirements
Module: cam_scaler

---
 rtl/cam_scaler.sv | 155 +++++++++++++++
 tb/tb_cam_scaler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cam_scaler.sv
// Maps screen raster coordinates onto a camera frame buffer (native, 2x, DDA stretch)
// and returns a 4-bit intensity slice as grey RGB, with video timing delayed to match.
module cam_scaler #(
  parameter  int SRC_H     = 320,
  parameter  int SRC_V     = 240,
  parameter  int SCR_H     = 1024,
  parameter  int SCR_V     = 768,
  parameter  int PIX_W     = 8,
  parameter  int SLICE_LSB = 2,
  parameter  int BRAM_LAT  = 2,
  localparam int ADDR_W    = $clog2(SRC_H*SRC_V)
) (
  input  logic              clk_65mhz,
  input  logic              rst_n,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  input  logic [1:0]        mode_in,
  input  logic [PIX_W-1:0]  frame_buff_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [11:0]       cam_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out
);

  localparam int ST = 1 + BRAM_LAT;
  localparam logic [10:0] H_NAT  = 11'(SRC_H);
  localparam logic [10:0] H_2X   = 11'(2*SRC_H);
  localparam logic [10:0] H_STR  = 11'(SCR_H);
  localparam logic [10:0] H_LAST = 11'(SCR_H-1);
  localparam logic [9:0]  V_NAT  = 10'(SRC_V);
  localparam logic [9:0]  V_2X   = 10'(2*SRC_V);
  localparam logic [9:0]  V_STR  = 10'(SCR_V);
  localparam logic [12:0] HSTEP  = 13'(SRC_H);
  localparam logic [12:0] HWRAP  = 13'(SCR_H);
  localparam logic [12:0] VSTEP  = 13'(SRC_V);
  localparam logic [12:0] VWRAP  = 13'(SCR_V);
  localparam logic [10:0] SX_MAX = 11'(SRC_H-1);
  localparam logic [9:0]  SY_MAX = 10'(SRC_V-1);
  localparam logic [ADDR_W-1:0] ROW = ADDR_W'(SRC_H);

  logic [1:0]  r_mode;
  logic [12:0] r_hacc, r_vacc;
  logic [10:0] r_sx;
  logic [9:0]  r_sy;
  logic [ST-1:0]      r_act_pipe;
  logic [ST-1:0][2:0] r_sync_pipe;

  logic        w_origin, w_h0, w_act;
  logic [1:0]  w_mode;
  logic [12:0] w_hacc_base, w_hsum, w_hacc_nxt;
  logic [12:0] w_vacc_base, w_vsum, w_vacc_nxt;
  logic [10:0] w_sx_base, w_sx_nxt, w_x;
  logic [9:0]  w_sy_base, w_sy_nxt, w_y;
  logic [ADDR_W-1:0] w_addr;
  logic        w_unused_pix;

  assign w_unused_pix = &{1'b0, frame_buff_in};

  // The origin pixel already belongs to the new frame, so the freshly sampled
  // mode and cleared vertical DDA are bypassed onto it.
  assign w_h0        = (hcount_in == 11'd0);
  assign w_origin    = w_h0 && (vcount_in == 10'd0);
  assign w_mode      = w_origin ? mode_in : r_mode;
  assign w_hacc_base = w_h0 ? 13'd0 : r_hacc;
  assign w_sx_base   = w_h0 ? 11'd0 : r_sx;
  assign w_vacc_base = w_origin ? 13'd0 : r_vacc;
  assign w_sy_base   = w_origin ? 10'd0 : r_sy;
  assign w_hsum      = w_hacc_base + HSTEP;
  assign w_vsum      = w_vacc_base + VSTEP;

  always_comb begin
    w_hacc_nxt = w_hsum;
    w_sx_nxt   = w_sx_base;
    if (w_hsum >= HWRAP) begin
      w_hacc_nxt = w_hsum - HWRAP;
      if (w_sx_base < SX_MAX) w_sx_nxt = w_sx_base + 11'd1;
    end
  end

  always_comb begin
    w_vacc_nxt = w_vsum;
    w_sy_nxt   = w_sy_base;
    if (w_vsum >= VWRAP) begin
      w_vacc_nxt = w_vsum - VWRAP;
      if (w_sy_base < SY_MAX) w_sy_nxt = w_sy_base + 10'd1;
    end
  end

  always_comb begin
    w_act = 1'b0;
    w_x   = '0;
    w_y   = '0;
    case (w_mode)
      2'd0: begin
        w_act = (hcount_in < H_NAT) && (vcount_in < V_NAT);
        w_x   = hcount_in;
        w_y   = vcount_in;
      end
      2'd1: begin
        w_act = (hcount_in < H_2X) && (vcount_in < V_2X);
        w_x   = {1'b0, hcount_in[10:1]};
        w_y   = {1'b0, vcount_in[9:1]};
      end
      2'd2: begin
        w_act = (hcount_in < H_STR) && (vcount_in < V_STR);
        w_x   = w_sx_base;
        w_y   = w_sy_base;
      end
      default: ;
    endcase
    w_addr = w_act ? (ADDR_W'(w_y) * ROW + ADDR_W'(w_x)) : '0;
  end

  always_ff @(posedge clk_65mhz) begin
    if (!rst_n) begin
      r_mode      <= 2'd3;
      r_hacc      <= '0;
      r_sx        <= '0;
      r_vacc      <= '0;
      r_sy        <= '0;
      addr_out    <= '0;
      r_act_pipe  <= '0;
      r_sync_pipe <= '0;
      cam_out     <= 12'h000;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      blank_out   <= 1'b1;
    end else begin
      if (w_origin) r_mode <= mode_in;
      if (hcount_in < H_STR) begin
        r_hacc <= w_hacc_nxt;
        r_sx   <= w_sx_nxt;
      end
      if (hcount_in == H_LAST) begin
        r_vacc <= w_vacc_nxt;
        r_sy   <= w_sy_nxt;
      end else if (w_origin) begin
        r_vacc <= '0;
        r_sy   <= '0;
      end
      addr_out    <= w_addr;
      r_act_pipe  <= {r_act_pipe[ST-2:0], w_act};
      r_sync_pipe <= {r_sync_pipe[ST-2:0], {hsync_in, vsync_in, blank_in}};
      // Pixel data lines up with the last active/timing stage.
      cam_out <= (r_act_pipe[ST-1] && !r_sync_pipe[ST-1][0]) ?
                 {3{frame_buff_in[SLICE_LSB+3:SLICE_LSB]}} : 12'h000;
      {hsync_out, vsync_out, blank_out} <= r_sync_pipe[ST-1];
    end
  end

endmodule

// File: tb/tb_cam_scaler.sv
// Randomized scoreboard bench for cam_scaler: a coordinate-level reference model
// predicts address and pixel/timing outputs; a monitor compares them as they appear.
module tb_cam_scaler;
  localparam int SRC_H = 320, SRC_V = 240, SCR_H = 1024, SCR_V = 768;

  logic        clk_65mhz = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, blank_in;
  logic [1:0]  mode_in;
  logic [7:0]  frame_buff_in;
  logic [16:0] addr_out;
  logic [11:0] cam_out;
  logic        hsync_out, vsync_out, blank_out;

  always #5 clk_65mhz = ~clk_65mhz;

  cam_scaler #(.SRC_H(SRC_H), .SRC_V(SRC_V), .SCR_H(SCR_H), .SCR_V(SCR_V),
               .PIX_W(8), .SLICE_LSB(2), .BRAM_LAT(2)) dut (
    .clk_65mhz(clk_65mhz), .rst_n(rst_n), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in), .mode_in(mode_in),
    .frame_buff_in(frame_buff_in), .addr_out(addr_out), .cam_out(cam_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out));

  // Frame buffer with two cycles of read latency
  logic [7:0] mem [0:SRC_H*SRC_V-1];
  logic [7:0] r_b1;
  always @(posedge clk_65mhz) begin
    r_b1          <= mem[addr_out];
    frame_buff_in <= r_b1;
  end

  typedef struct { int due; int addr; } a_t;
  typedef struct { int due; logic [11:0] cam; logic hs; logic vs; logic bl; } o_t;
  a_t aq[$];
  o_t oq[$];
  a_t ma;
  o_t mo;
  int edge_cnt = 0, n_chk = 0, n_pass = 0;
  int f_mode = 3;

  always @(posedge clk_65mhz) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0h exp=%0h", nm, edge_cnt, got, exp);
  endtask

  always @(negedge clk_65mhz) begin
    while (aq.size() > 0 && aq[0].due <= edge_cnt) begin
      ma = aq.pop_front();
      chk("addr", 32'(addr_out), 32'(ma.addr));
    end
    while (oq.size() > 0 && oq[0].due <= edge_cnt) begin
      mo = oq.pop_front();
      chk("cam",   32'(cam_out),   32'(mo.cam));
      chk("hsync", 32'(hsync_out), 32'(mo.hs));
      chk("vsync", 32'(vsync_out), 32'(mo.vs));
      chk("blank", 32'(blank_out), 32'(mo.bl));
    end
  end

  // One input cycle; expectations derived from screen coordinates directly.
  task automatic step(input int h, input int v, input int md, input bit rst, input bit vis);
    bit act;
    int x, y, a, e;
    o_t o;
    @(posedge clk_65mhz); #1;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    mode_in   = 2'(md);
    rst_n     = !rst;
    hsync_in  = ($urandom % 8) == 0;
    vsync_in  = ($urandom % 16) == 0;
    blank_in  = vis ? 1'b0 : (($urandom % 6) == 0);
    e = edge_cnt + 1;
    if (rst) begin
      f_mode = 3;
      aq.push_back('{e, 0});
      oq.push_back('{e + 3, 12'h000, 1'b0, 1'b0, 1'b0});
      foreach (oq[i]) begin
        if (oq[i].due == e) oq[i] = '{e, 12'h000, 1'b0, 1'b0, 1'b1};
        else if (oq[i].due > e) oq[i] = '{oq[i].due, 12'h000, 1'b0, 1'b0, 1'b0};
      end
    end else begin
      if (h == 0 && v == 0) f_mode = md;
      act = 0; x = 0; y = 0;
      case (f_mode)
        0: begin act = (h < SRC_H) && (v < SRC_V); x = h; y = v; end
        1: begin act = (h < 2*SRC_H) && (v < 2*SRC_V); x = h / 2; y = v / 2; end
        2: begin
          act = (h < SCR_H) && (v < SCR_V);
          x = (h * SRC_H) / SCR_H;
          y = (v * SRC_V) / SCR_V;
          if (x > SRC_H - 1) x = SRC_H - 1;
          if (y > SRC_V - 1) y = SRC_V - 1;
        end
        default: act = 0;
      endcase
      a = act ? (y * SRC_H + x) : 0;
      aq.push_back('{e, a});
      o.due = e + 3;
      o.cam = (act && !blank_in) ? {3{mem[a][5:2]}} : 12'h000;
      o.hs  = hsync_in;
      o.vs  = vsync_in;
      o.bl  = blank_in;
      oq.push_back(o);
    end
  endtask

  task automatic rand_pts(input int n);
    int h, v;
    repeat (n) begin
      h = $urandom_range(0, 1343);
      v = $urandom_range(0, 805);
      if (h == 0 && v == 0) h = 1;
      step(h, v, $urandom % 4, 0, 0);
    end
  endtask

  // Lines not checked in full present only their last column so the vertical
  // DDA still advances once per line.
  task automatic stretch_frame();
    int full2;
    full2 = $urandom_range(1, 766);
    for (int v = 0; v <= 770; v++) begin
      if (v == 0 || v == full2 || v == 767) begin
        for (int h = 0; h <= 1100; h++)
          step(h, v, (h == 0 && v == 0) ? 2 : int'($urandom % 4), 0, 0);
      end else begin
        step(1023, v, $urandom % 4, 0, 0);
      end
    end
  endtask

  initial begin
    int m;
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[645] = 8'h34;
    rst_n = 1'b0; hcount_in = '0; vcount_in = '0; mode_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
    repeat (4) step(0, 0, 0, 1, 0);
    // native frame with directed corners
    step(0, 0, 0, 0, 0);
    step(5, 2, 1, 0, 1);
    step(319, 239, 2, 0, 1);
    step(320, 0, 3, 0, 1);
    step(0, 240, 1, 0, 1);
    rand_pts(150);
    // 2x frame; mode_in moves to stretch mid-frame
    step(0, 0, 1, 0, 0);
    step(639, 479, 0, 0, 1);
    step(640, 479, 0, 0, 1);
    step(639, 480, 0, 0, 1);
    step(10, 100, 2, 0, 1);
    rand_pts(150);
    stretch_frame();
    // reset in the middle of an active native line
    step(0, 0, 0, 0, 0);
    for (int h = 1; h < 20; h++) step(h, 7, 0, 0, 1);
    step(20, 7, 0, 1, 1);
    step(21, 7, 0, 1, 1);
    for (int h = 22; h < 40; h++) step(h, 7, 0, 0, 1);
    repeat (6) begin
      m = $urandom % 3;
      if (m == 2) m = 3;
      step(0, 0, m, 0, 0);
      rand_pts(120);
    end
    stretch_frame();
    repeat (6) step(1300, 0, 0, 0, 0);
    repeat (6) @(negedge clk_65mhz);
    #1;
    chk("drain", 32'(aq.size() + oq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
